// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - main control FSM of the multi-cycle MIPS CPU
//
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives ALU op code, operand selects and all datapath enables.
// Build option: define ILLEGAL_HALT_EN to trap unsupported instructions in
// HALT until reset; otherwise they are retired as a nop with a 1-cycle flag.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   opcode, funct   IR fields, stable from DECODE until the next FETCH
//   zero            ALU zero flag, used in BRANCH
//   alu_control     ALU op code
//   alu_src_a/b     ALU operand selects
//   pc_en, pc_source PC load enable and PC source select
//   i_or_d          memory address select (0 PC, 1 ALUOut)
//   mem_read/write  memory strobes
//   ir_write        IR load enable
//   reg_dst, mem_to_reg, reg_write  register file controls
//   illegal         unsupported instruction flag
//   state           current state, for debug
module mc_control_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_control,
    output logic [1:0] alu_src_a,
    output logic [2:0] alu_src_b,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_WB_R      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_EXEC_I    = 4'd10;
    localparam logic [3:0] S_WB_I      = 4'd11;
    localparam logic [3:0] S_HALT      = 4'd15;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_LUI = 4'd5;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd8;
    localparam logic [3:0] ALU_XOR = 4'd9;

    // Where an unsupported instruction goes once detected
`ifdef ILLEGAL_HALT_EN
    localparam logic [3:0] S_TRAP = S_HALT;
`else
    localparam logic [3:0] S_TRAP = S_FETCH;
`endif

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       funct_ok;
    logic [3:0] r_alu;
    logic       r_shift;

    // R-type funct decode, shared by next-state and output logic
    always_comb begin
        funct_ok = 1'b1;
        r_alu    = ALU_ADD;
        r_shift  = 1'b0;
        case (funct)
            6'h20: r_alu = ALU_ADD;
            6'h22: r_alu = ALU_SUB;
            6'h24: r_alu = ALU_AND;
            6'h25: r_alu = ALU_OR;
            6'h26: r_alu = ALU_XOR;
            6'h27: r_alu = ALU_NOR;
            6'h2A: r_alu = ALU_SLT;
            6'h00: begin r_alu = ALU_SLL; r_shift = 1'b1; end
            6'h02: begin r_alu = ALU_SRL; r_shift = 1'b1; end
            default: funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    6'h23, 6'h2B:                      state_d = S_MEM_ADDR;
                    6'h00:                             state_d = S_EXEC_R;
                    6'h04, 6'h05:                      state_d = S_BRANCH;
                    6'h02:                             state_d = S_JUMP;
                    6'h08, 6'h0A, 6'h0C,
                    6'h0D, 6'h0E, 6'h0F:               state_d = S_EXEC_I;
                    default:                           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == 6'h23) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_EXEC_R:    state_d = funct_ok ? S_WB_R : S_TRAP;
            S_EXEC_I:    state_d = S_WB_I;
`ifdef ILLEGAL_HALT_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        alu_control = ALU_ADD;
        alu_src_a   = 2'b00;
        alu_src_b   = 3'b000;
        pc_en       = 1'b0;
        pc_source   = 2'b00;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = 3'b001;
                pc_en     = 1'b1;
            end
            S_DECODE: begin
                alu_src_b = 3'b011;
`ifndef ILLEGAL_HALT_EN
                case (opcode)
                    6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02,
                    6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: illegal = 1'b0;
                    default:                                    illegal = 1'b1;
                endcase
`endif
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'b01;
                alu_src_b = 3'b010;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                if (funct_ok) begin
                    alu_control = r_alu;
                    // shifts take rt as the operand and shamt from the immediate field
                    alu_src_a   = r_shift ? 2'b10 : 2'b01;
                    alu_src_b   = r_shift ? 3'b010 : 3'b000;
                end else begin
`ifndef ILLEGAL_HALT_EN
                    illegal = 1'b1;
`endif
                end
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b01;
                alu_control = ALU_SUB;
                pc_source   = 2'b01;
                // only combinational input dependence: branch resolution
                pc_en       = (opcode == 6'h05) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b01;
                case (opcode)
                    6'h0A:   begin alu_control = ALU_SLT; alu_src_b = 3'b010; end
                    6'h0C:   begin alu_control = ALU_AND; alu_src_b = 3'b100; end
                    6'h0D:   begin alu_control = ALU_OR;  alu_src_b = 3'b100; end
                    6'h0E:   begin alu_control = ALU_XOR; alu_src_b = 3'b100; end
                    6'h0F:   begin alu_control = ALU_LUI; alu_src_b = 3'b100; end
                    default: begin alu_control = ALU_ADD; alu_src_b = 3'b010; end
                endcase
            end
            S_WB_I: begin
                reg_write = 1'b1;
            end
`ifdef ILLEGAL_HALT_EN
            S_HALT: begin
                illegal = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] alu_control;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, illegal;
    logic [3:0] state;

    mc_control_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_en(pc_en), .pc_source(pc_source), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] F_IORD = 8'h80;
    localparam logic [7:0] F_MR   = 8'h40;
    localparam logic [7:0] F_MW   = 8'h20;
    localparam logic [7:0] F_IRW  = 8'h10;
    localparam logic [7:0] F_RD   = 8'h08;
    localparam logic [7:0] F_M2R  = 8'h04;
    localparam logic [7:0] F_RW   = 8'h02;
    localparam logic [7:0] F_ILL  = 8'h01;

    typedef struct {
        string       tag;
        logic [23:0] val;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    wire [23:0] obs = {state, alu_control, alu_src_a, alu_src_b, pc_en, pc_source,
                       i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, illegal};

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [23:0] v(input logic [3:0] st, input logic [3:0] alu,
                                      input logic [1:0] sa, input logic [2:0] sb,
                                      input logic pce, input logic [1:0] pcs,
                                      input logic [7:0] fl);
        return {st, alu, sa, sb, pce, pcs, fl};
    endfunction

    task automatic push(input string tag, input logic [23:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check_eq(e.tag, obs, e.val);
        end
    end

    // Called at the start of a FETCH cycle; queues the whole instruction's
    // per-cycle expectations and then lets it run to the next FETCH.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int          n;
        logic        bad_op;
        logic [3:0]  alu;
        logic [1:0]  sa;
        logic [2:0]  sb;
        logic        ok;
        string       t;
        opcode = op;
        funct  = fn;
        zero   = z;
        t = $sformatf("op%02h/fn%02h/z%0d", op, fn, z);
        bad_op = !(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02,
                              6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F});
        push({t, " fetch"}, v(4'd0, 4'd2, 2'b00, 3'b001, 1'b1, 2'b00, F_MR | F_IRW));
        push({t, " decode"}, v(4'd1, 4'd2, 2'b00, 3'b011, 1'b0, 2'b00, bad_op ? F_ILL : 8'h00));
        n = 2;
        case (op)
            6'h23: begin
                push({t, " maddr"}, v(4'd2, 4'd2, 2'b01, 3'b010, 1'b0, 2'b00, 8'h00));
                push({t, " mread"}, v(4'd3, 4'd2, 2'b00, 3'b000, 1'b0, 2'b00, F_IORD | F_MR));
                push({t, " mwb"},   v(4'd4, 4'd2, 2'b00, 3'b000, 1'b0, 2'b00, F_M2R | F_RW));
                n = 5;
            end
            6'h2B: begin
                push({t, " maddr"}, v(4'd2, 4'd2, 2'b01, 3'b010, 1'b0, 2'b00, 8'h00));
                push({t, " mwrite"}, v(4'd5, 4'd2, 2'b00, 3'b000, 1'b0, 2'b00, F_IORD | F_MW));
                n = 4;
            end
            6'h00: begin
                ok = 1'b1; sa = 2'b01; sb = 3'b000; alu = 4'd2;
                case (fn)
                    6'h20: alu = 4'd2;
                    6'h22: alu = 4'd6;
                    6'h24: alu = 4'd0;
                    6'h25: alu = 4'd1;
                    6'h26: alu = 4'd9;
                    6'h27: alu = 4'd8;
                    6'h2A: alu = 4'd7;
                    6'h00: begin alu = 4'd3; sa = 2'b10; sb = 3'b010; end
                    6'h02: begin alu = 4'd4; sa = 2'b10; sb = 3'b010; end
                    default: ok = 1'b0;
                endcase
                if (ok) begin
                    push({t, " exec_r"}, v(4'd6, alu, sa, sb, 1'b0, 2'b00, 8'h00));
                    push({t, " wb_r"},   v(4'd7, 4'd2, 2'b00, 3'b000, 1'b0, 2'b00, F_RD | F_RW));
                    n = 4;
                end else begin
                    push({t, " exec_r_ill"}, v(4'd6, 4'd2, 2'b00, 3'b000, 1'b0, 2'b00, F_ILL));
                    n = 3;
                end
            end
            6'h04, 6'h05: begin
                push({t, " branch"}, v(4'd8, 4'd6, 2'b01, 3'b000,
                                       (op == 6'h04) ? z : ~z, 2'b01, 8'h00));
                n = 3;
            end
            6'h02: begin
                push({t, " jump"}, v(4'd9, 4'd2, 2'b00, 3'b000, 1'b1, 2'b10, 8'h00));
                n = 3;
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                case (op)
                    6'h08:   begin alu = 4'd2; sb = 3'b010; end
                    6'h0A:   begin alu = 4'd7; sb = 3'b010; end
                    6'h0C:   begin alu = 4'd0; sb = 3'b100; end
                    6'h0D:   begin alu = 4'd1; sb = 3'b100; end
                    6'h0E:   begin alu = 4'd9; sb = 3'b100; end
                    default: begin alu = 4'd5; sb = 3'b100; end
                endcase
                push({t, " exec_i"}, v(4'd10, alu, 2'b01, sb, 1'b0, 2'b00, 8'h00));
                push({t, " wb_i"},   v(4'd11, 4'd2, 2'b00, 3'b000, 1'b0, 2'b00, F_RW));
                n = 4;
            end
            default: n = 2;
        endcase
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 6'h00;
        funct  = 6'h20;
        zero   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run(6'h23, 6'h00, 1'b0);
        run(6'h2B, 6'h00, 1'b0);
        run(6'h00, 6'h02, 1'b0);
        run(6'h00, 6'h00, 1'b0);
        run(6'h00, 6'h20, 1'b0);
        run(6'h00, 6'h22, 1'b1);
        run(6'h00, 6'h24, 1'b0);
        run(6'h00, 6'h25, 1'b0);
        run(6'h00, 6'h26, 1'b0);
        run(6'h00, 6'h27, 1'b0);
        run(6'h00, 6'h2A, 1'b0);
        run(6'h05, 6'h00, 1'b1);
        run(6'h05, 6'h00, 1'b0);
        run(6'h04, 6'h00, 1'b1);
        run(6'h04, 6'h00, 1'b0);
        run(6'h02, 6'h00, 1'b1);
        run(6'h0F, 6'h00, 1'b0);
        run(6'h0D, 6'h00, 1'b0);
        run(6'h08, 6'h00, 1'b0);
        run(6'h0A, 6'h00, 1'b0);
        run(6'h0C, 6'h00, 1'b0);
        run(6'h0E, 6'h00, 1'b0);

`ifndef ILLEGAL_HALT_EN
        run(6'h3F, 6'h00, 1'b0);
        run(6'h00, 6'h3F, 1'b0);
        run(6'h23, 6'h00, 1'b0);
`else
        opcode = 6'h3F;
        funct  = 6'h00;
        push("halt fetch", v(4'd0, 4'd2, 2'b00, 3'b001, 1'b1, 2'b00, F_MR | F_IRW));
        push("halt decode", v(4'd1, 4'd2, 2'b00, 3'b011, 1'b0, 2'b00, 8'h00));
        for (int i = 0; i < 11; i++)
            push($sformatf("halt hold%0d", i), v(4'd15, 4'd2, 2'b00, 3'b000, 1'b0, 2'b00, F_ILL));
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(6'h0D, 6'h00, 1'b0);
`endif

        // reset taken in the middle of a load, during MEM_READ
        opcode = 6'h23;
        push("rst_mid fetch", v(4'd0, 4'd2, 2'b00, 3'b001, 1'b1, 2'b00, F_MR | F_IRW));
        push("rst_mid decode", v(4'd1, 4'd2, 2'b00, 3'b011, 1'b0, 2'b00, 8'h00));
        push("rst_mid maddr", v(4'd2, 4'd2, 2'b01, 3'b010, 1'b0, 2'b00, 8'h00));
        push("rst_mid mread", v(4'd3, 4'd2, 2'b00, 3'b000, 1'b0, 2'b00, F_IORD | F_MR));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(6'h2B, 6'h00, 1'b0);

        @(negedge clk);
        check_eq("drain", 24'(q.size()), 24'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
